mpc_cfg_loader: RTL and testbench

MPC_CFG_LOADER -- requirements
Module: mpc_cfg_loader

---
 rtl/mpc_cfg_loader.sv | 213 +++++++++++++++++++++
 tb/tb_mpc_cfg_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_cfg_loader.sv
// Serial configuration loader for the multi-protocol IO mux.
// Accepts 8-bit sync+config frames and applies changes with break-before-make blanking.
module mpc_cfg_loader #(
    parameter logic [3:0]  SYNC      = 4'hA,
    parameter logic [3:0]  RESET_CFG = 4'h0,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    input  logic       cfg_sdi,
    output logic [3:0] configuration,
    output logic       cfg_blank,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_err
);

    localparam int unsigned FRAME_W = 8;
    localparam int unsigned CFG_W   = 4;
    localparam int unsigned BITC_W  = 4;
    localparam int unsigned GAP_W   = 8;
    localparam int unsigned SET_W   = 4;

    localparam logic [BITC_W-1:0] LAST_BIT = BITC_W'(FRAME_W);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT - 1);
    localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SHIFT      = 3'd1,
        ST_CHECK      = 3'd2,
        ST_BLANK_PRE  = 3'd3,
        ST_BLANK_POST = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [FRAME_W-1:0]  r_shift;
    logic [BITC_W-1:0]   r_bitcnt;
    logic [GAP_W-1:0]    r_gap;
    logic [SET_W-1:0]    r_settle;
    logic [CFG_W-1:0]    r_cfg;
    logic                r_blank;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [FRAME_W-1:0]  w_shift_nxt;
    logic [BITC_W-1:0]   w_bitcnt_nxt;
    logic [GAP_W-1:0]    w_gap_nxt;
    logic [SET_W-1:0]    w_settle_nxt;
    logic [CFG_W-1:0]    w_cfg_nxt;
    logic                w_blank_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;

    logic                w_sync_ok;
    logic                w_same_cfg;
    logic                w_gap_expired;

    assign w_sync_ok     = (r_shift[FRAME_W-1:CFG_W] == SYNC);
    assign w_same_cfg    = (r_shift[CFG_W-1:0] == r_cfg);
    assign w_gap_expired = !cfg_valid && (r_gap == GAP_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bitcnt == LAST_BIT) begin
                    w_next_state = ST_CHECK;
                end else if (w_gap_expired) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!w_sync_ok || w_same_cfg) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_BLANK_PRE;
                end
            end
            ST_BLANK_PRE: begin
                if (r_settle == SET_LAST) begin
                    w_next_state = ST_BLANK_POST;
                end
            end
            ST_BLANK_POST: begin
                if (r_settle == SET_LAST) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values; busy/blank follow the state being entered
    always_comb begin
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_gap_nxt    = r_gap;
        w_settle_nxt = r_settle;
        w_cfg_nxt    = r_cfg;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_blank_nxt  = (w_next_state == ST_BLANK_PRE) || (w_next_state == ST_BLANK_POST);
        w_busy_nxt   = (w_next_state == ST_CHECK) || w_blank_nxt;

        case (r_state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    w_shift_nxt  = {r_shift[FRAME_W-2:0], cfg_sdi};
                    w_bitcnt_nxt = BITC_W'(1);
                    w_gap_nxt    = '0;
                end
            end
            ST_SHIFT: begin
                if (r_bitcnt == LAST_BIT) begin
                    w_settle_nxt = '0;
                end else if (cfg_valid) begin
                    w_shift_nxt  = {r_shift[FRAME_W-2:0], cfg_sdi};
                    w_bitcnt_nxt = r_bitcnt + BITC_W'(1);
                    w_gap_nxt    = '0;
                end else if (w_gap_expired) begin
                    w_err_nxt    = 1'b1;
                    w_gap_nxt    = '0;
                    w_bitcnt_nxt = '0;
                end else begin
                    w_gap_nxt    = r_gap + GAP_W'(1);
                end
            end
            ST_CHECK: begin
                w_settle_nxt = '0;
                if (!w_sync_ok) begin
                    w_err_nxt  = 1'b1;
                end else if (w_same_cfg) begin
                    w_done_nxt = 1'b1;
                end
            end
            ST_BLANK_PRE: begin
                if (r_settle == SET_LAST) begin
                    w_settle_nxt = '0;
                    w_cfg_nxt    = r_shift[CFG_W-1:0];
                end else begin
                    w_settle_nxt = r_settle + SET_W'(1);
                end
            end
            ST_BLANK_POST: begin
                if (r_settle == SET_LAST) begin
                    w_settle_nxt = '0;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_settle_nxt = r_settle + SET_W'(1);
                end
            end
            default: begin
                w_settle_nxt = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_gap    <= '0;
            r_settle <= '0;
            r_cfg    <= RESET_CFG;
            r_blank  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_gap    <= w_gap_nxt;
            r_settle <= w_settle_nxt;
            r_cfg    <= w_cfg_nxt;
            r_blank  <= w_blank_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign configuration = r_cfg;
    assign cfg_blank     = r_blank;
    assign cfg_busy      = r_busy;
    assign cfg_done      = r_done;
    assign cfg_err       = r_err;

endmodule

// File: tb/tb_mpc_cfg_loader.sv
// Directed bench for mpc_cfg_loader with default parameters (SYNC=A, SETTLE=4, TIMEOUT=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mpc_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_sdi;
    logic [3:0] configuration;
    logic       cfg_blank;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    mpc_cfg_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_sdi       (cfg_sdi),
        .configuration (configuration),
        .cfg_blank     (cfg_blank),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Observed vector: {configuration, blank, busy, done, err}
    function automatic logic [7:0] obs();
        return {configuration, cfg_blank, cfg_busy, cfg_done, cfg_err};
    endfunction

    // Eight bits MSB first, then one idle negedge (k=0 reference point)
    task automatic drive_frame(input logic [7:0] f);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_sdi   = f[i];
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_sdi   = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_sdi   = 1'b0;
        repeat (2) @(negedge clk);
        got = obs();
        n_tests++;
        if (got !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=%h", got, 8'h00);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        got = obs();
        n_tests++;
        if (got !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", got, 8'h00);
        end
    endtask

    task automatic test_change();
        logic [7:0] got, exp;
        drive_frame(8'hA3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = {(k >= 6) ? 4'h3 : 4'h0, (k >= 2 && k <= 9), (k >= 1 && k <= 9), (k == 10), 1'b0};
            got = obs();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL change_A3 k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_same_value();
        logic [7:0] got, exp;
        drive_frame(8'hA3);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp = {4'h3, 1'b0, (k == 1), (k == 2), 1'b0};
            got = obs();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL same_A3 k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_sync_error();
        logic [7:0] got, exp;
        drive_frame(8'h53);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp = {4'h3, 1'b0, (k == 1), 1'b0, (k == 2)};
            got = obs();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL sync_err_53 k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] got, exp;
        logic [4:0] part;
        part = 5'b10100;
        for (int i = 4; i >= 0; i--) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_sdi   = part[i];
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_sdi   = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            exp = {4'h3, 1'b0, 1'b0, 1'b0, (k == 16)};
            got = obs();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL timeout k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        drive_frame(8'hA1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = {(k >= 6) ? 4'h1 : 4'h3, (k >= 2 && k <= 9), (k >= 1 && k <= 9), (k == 10), 1'b0};
            got = obs();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL after_timeout_A1 k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_blank();
        logic [7:0] got, exp;
        drive_frame(8'hA7);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
        end
        got = obs();
        n_tests++;
        if (got !== 8'h7C) begin
            n_fail++;
            $display("FAIL pre_reset_blank_post got=%h exp=%h", got, 8'h7C);
        end
        rst_n = 1'b0;
        #1;
        got = obs();
        n_tests++;
        if (got !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_immediate got=%h exp=%h", got, 8'h00);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp = 8'h00;
            got = obs();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_abort k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] got, exp;
        drive_frame(8'hA5);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = {(k >= 6) ? 4'h5 : 4'h0, (k >= 2 && k <= 9), (k >= 1 && k <= 9), (k == 10), 1'b0};
            got = obs();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL ignore_busy k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k <= 9) begin
                cfg_valid = (k % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                cfg_sdi   = cfg_valid ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                cfg_valid = 1'b0;
                cfg_sdi   = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, exp;
        logic [7:0] f2;
        f2 = 8'hA6;
        drive_frame(8'hA5);
        @(negedge clk);
        got = obs();
        n_tests++;
        if (got !== 8'h54) begin
            n_fail++;
            $display("FAIL b2b_check got=%h exp=%h", got, 8'h54);
        end
        @(negedge clk);
        got = obs();
        n_tests++;
        if (got !== 8'h52) begin
            n_fail++;
            $display("FAIL b2b_done got=%h exp=%h", got, 8'h52);
        end
        cfg_valid = 1'b1;
        cfg_sdi   = f2[7];
        for (int i = 6; i >= 0; i--) begin
            @(negedge clk);
            cfg_sdi = f2[i];
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_sdi   = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = {(k >= 6) ? 4'h6 : 4'h5, (k >= 2 && k <= 9), (k >= 1 && k <= 9), (k == 10), 1'b0};
            got = obs();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL b2b_A6 k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_change();
        test_same_value();
        test_sync_error();
        test_timeout();
        test_reset_mid_blank();
        test_ignore_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
